uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  Host-link UART receiver (8N1) upstream of the command FIFO that feeds tlc5955_control.
//  Deserialises rx into bytes and pushes each one through the fifo_sync write port (write_en/write_data).
//  Flags overflow, framing errors and line breaks so the host link can resynchronise.
//  Single clock domain; rx is asynchronous to clk and is synchronised internally.
// PARAMETERS
//  ClksPerBit   434  clk ticks per bit (50 MHz / 115200); even, >= 8
//  CntWidth     16   counter width; must satisfy 2**CntWidth > ClksPerBit
// PORTS
//  clk             in   1  system clock
//  reset           in   1  asynchronous, active-low reset
//  rx              in   1  serial input, idle high, async to clk
//  fifo_full       in   1  from command fifo_sync
//  write_en        out  1  one-cycle push strobe to command fifo_sync
//  write_data      out  8  received byte, valid while write_en=1
//  overflow        out  1  sticky: a completed byte was dropped because fifo_full=1
//  clear_overflow  in   1  synchronous clear of overflow
//  frame_err       out  1  one-cycle pulse: stop bit sampled low
//  break_det       out  1  one-cycle pulse: data=0x00 and stop bit low
//  busy            out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): rx sync flops=1, state=IDLE, counters=0, all outputs 0.
//  - rx passes through a 2-FF synchroniser (rx_s); rx_s lags rx by 2 clk.
//  - FSM: IDLE, START, DATA, STOP, WAIT_IDLE.
//  - IDLE: rx_s=0 -> START; bit counter loaded with ClksPerBit/2-1.
//  - START: on counter expiry, rx_s=0 -> DATA (counter=ClksPerBit-1, bit index=0);
//    rx_s=1 -> IDLE (glitch rejected; no output).
//  - DATA: on each expiry sample rx_s into shift reg, LSB first; after bit 7 -> STOP.
//  - STOP: on expiry sample rx_s.
//    1: if fifo_full=0, write_en=1 with write_data=byte for exactly 1 clk; else set overflow
//       (write_en stays 0). -> IDLE.
//    0: frame_err pulse; also break_det pulse if byte=0x00; byte discarded -> WAIT_IDLE.
//  - WAIT_IDLE: stay until rx_s=1, then -> IDLE (no false start during a break).
//  - Latency: write_en asserted exactly 2 + ClksPerBit/2 + 9*ClksPerBit + 1 clk after rx falls
//    (155 clk at ClksPerBit=16).
//  - Back-to-back frames: STOP->IDLE at mid-stop-bit, so a start edge half a bit later is caught.
//  - overflow: set when a byte is dropped; cleared when clear_overflow=1.
//    Set and clear in the same cycle -> stays set.
//  - fifo_full is sampled only in the STOP-expiry cycle; it is never latched earlier.
//  - write_data holds its last value after write_en falls; only qualified by write_en.
//  - Reset mid-frame: immediate return to IDLE; a partial byte is never written.
//  - Counter arithmetic: decrement to 0, reload; widths truncated to CntWidth.
// STRUCTURE
//  - uart_defs.vh (shared include): state encodings (UART_IDLE..UART_WAIT_IDLE, 3 bits).
//    It also holds the default ClksPerBit for the 50 MHz system clock.
//  - Sub-module sync_2ff (reset value parameterised, here 1): rx synchroniser, reusable for miso.
//  - Remainder is one FSM + bit counter + 3-bit index + 8-bit shift register.
// TESTING  (ClksPerBit=16, drive rx from a bit-accurate task)
//  1 Send 0xA5 with fifo_full=0 -> single write_en pulse, write_data=8'hA5, 155 clk after start edge.
//  2 Send 0x00,0xFF,0x3C back-to-back (no idle gap) -> three write_en pulses, data 00,FF,3C in order.
//  3 Hold fifo_full=1, send 0x42 -> no write_en, overflow=1.
//    Then clear_overflow=1 for 1 clk -> overflow=0.
//  4 Send 0x81 with stop bit driven 0 -> frame_err 1-cycle pulse, no write_en, break_det=0.
//  5 Hold rx low for 30 bit-times, then release -> one frame_err + one break_det pulse.
//    No further events until rx high; a following 0x55 is received correctly.
//  6 Low glitch of 4 clk on idle rx -> busy returns 0, no outputs.
//    Separately, assert reset mid-DATA -> all outputs 0 and no write_en; next 0x12 received OK.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the host-link UART receiver.
// State encoding and default bit timing.
package uart_cmd_rx_pkg;

  typedef enum logic [2:0] {
    UART_IDLE      = 3'd0,
    UART_START     = 3'd1,
    UART_DATA      = 3'd2,
    UART_STOP      = 3'd3,
    UART_WAIT_IDLE = 3'd4
  } uart_state_e;

  // 50 MHz system clock at 115200 baud
  localparam int unsigned DefaultClksPerBit = 434;
  localparam int unsigned DefaultCntWidth   = 16;

endpackage

// File: rtl/uart_cmd_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input.
// Reset value is a parameter so idle-high lines start idle.
module uart_cmd_rx_sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= ResetVal;
      q    <= ResetVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver feeding the command fifo write port.
// Reports overflow, framing errors and line breaks.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned ClksPerBit = DefaultClksPerBit,
  parameter int unsigned CntWidth   = DefaultCntWidth
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       fifo_full,
  output logic       write_en,
  output logic [7:0] write_data,
  output logic       overflow,
  input  logic       clear_overflow,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam logic [CntWidth-1:0] HalfLoad =
    CntWidth'(ClksPerBit / 2 - 1);
  localparam logic [CntWidth-1:0] FullLoad =
    CntWidth'(ClksPerBit - 1);
  localparam logic [CntWidth-1:0] One =
    CntWidth'(1);

  uart_state_e         state;
  logic [CntWidth-1:0] cnt;
  logic [2:0]          idx;
  logic [7:0]          shreg;
  logic                rx_s;
  logic                expire;

  uart_cmd_rx_sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync_2ff (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign expire = (cnt == '0);
  assign busy   = (state != UART_IDLE);

  // Frame FSM with bit timer, shift register and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= UART_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      write_en   <= 1'b0;
      write_data <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      write_en  <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      // a drop later in this block overrides the clear
      if (clear_overflow) overflow <= 1'b0;
      unique case (state)
        UART_IDLE: begin
          if (!rx_s) begin
            state <= UART_START;
            cnt   <= HalfLoad;
          end
        end
        UART_START: begin
          if (!expire) begin
            cnt <= cnt - One;
          end else if (!rx_s) begin
            state <= UART_DATA;
            cnt   <= FullLoad;
            idx   <= '0;
          end else begin
            state <= UART_IDLE;
          end
        end
        UART_DATA: begin
          if (!expire) begin
            cnt <= cnt - One;
          end else begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FullLoad;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= UART_STOP;
          end
        end
        UART_STOP: begin
          if (!expire) begin
            cnt <= cnt - One;
          end else if (rx_s) begin
            state <= UART_IDLE;
            if (!fifo_full) begin
              write_en   <= 1'b1;
              write_data <= shreg;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            state     <= UART_WAIT_IDLE;
            frame_err <= 1'b1;
            break_det <= (shreg == 8'h00);
          end
        end
        UART_WAIT_IDLE: begin
          if (rx_s) state <= UART_IDLE;
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx at 16 clk per bit.
// Directed steps plus a randomized frame mix against a frame model.
module tb_uart_cmd_rx;

  localparam int Cpb = 16;
  localparam int Lat = 2 + Cpb / 2 + 9 * Cpb + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       fifo_full = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       write_en;
  logic [7:0] write_data;
  logic       overflow;
  logic       frame_err;
  logic       break_det;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_n = 0;
  int bk_n = 0;
  int fe_w = 0;
  int wq_d[$];
  int wq_t[$];

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .ClksPerBit(Cpb),
    .CntWidth  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .fifo_full     (fifo_full),
    .write_en      (write_en),
    .write_data    (write_data),
    .overflow      (overflow),
    .clear_overflow(clear_overflow),
    .frame_err     (frame_err),
    .break_det     (break_det),
    .busy          (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      wq_d.push_back(int'(write_data));
      wq_t.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_n++;
    if (break_det === 1'b1) bk_n++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flush();
    wq_d.delete();
    wq_t.delete();
    fe_n = 0;
    bk_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a negedge; drives one full 8N1 frame
  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            output int t0);
    t0 = cyc;
    rx = 1'b0;
    idle(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(Cpb);
    end
    rx = stop;
    idle(Cpb);
  endtask

  logic [7:0] b;
  logic       st;
  logic       ff;
  logic       ov_exp;
  int         t;
  int         fe_exp;
  int         bk_exp;
  int         exp_q[$];
  logic [7:0] seq3 [3];

  initial begin
    #1;
    check("reset_outs",
          {27'd0, write_en, overflow, frame_err, break_det, busy},
          32'd0);
    check("reset_data", {24'd0, write_data}, 32'd0);
    idle(3);
    reset = 1'b1;
    idle(Cpb);

    // 1: single byte and latency
    flush();
    send_frame(8'hA5, 1'b1, t);
    idle(Cpb);
    check("t1_count", wq_d.size(), 1);
    if (wq_d.size() == 1) begin
      check("t1_data", wq_d[0], 32'hA5);
      check("t1_latency", wq_t[0] - t, Lat);
    end
    check("t1_hold", {24'd0, write_data}, 32'hA5);

    // 2: back-to-back frames
    flush();
    seq3[0] = 8'h00;
    seq3[1] = 8'hFF;
    seq3[2] = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(seq3[i], 1'b1, t);
    idle(Cpb);
    check("t2_count", wq_d.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wq_d.size())
        check("t2_data", wq_d[i], {24'd0, seq3[i]});
    check("t2_noerr", fe_n + bk_n, 0);

    // 3: overflow, then clear
    flush();
    fifo_full = 1'b1;
    send_frame(8'h42, 1'b1, t);
    fifo_full = 1'b0;
    idle(Cpb);
    check("t3_nowrite", wq_d.size(), 0);
    check("t3_ovf_set", {31'd0, overflow}, 32'd1);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    check("t3_ovf_clr", {31'd0, overflow}, 32'd0);

    // 3b: set and clear together keeps overflow set
    fork
      send_frame(8'h24, 1'b1, t);
      begin
        fifo_full = 1'b1;
        clear_overflow = 1'b1;
        idle(Lat);
        clear_overflow = 1'b0;
        fifo_full = 1'b0;
        check("t3_set_wins", {31'd0, overflow}, 32'd1);
      end
    join
    idle(Cpb);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    check("t3_nowrite2", wq_d.size(), 0);

    // 3c: fifo_full only matters at the stop sample
    flush();
    fork
      send_frame(8'h99, 1'b1, t);
      begin
        fifo_full = 1'b1;
        idle(Lat - 6);
        fifo_full = 1'b0;
      end
    join
    idle(Cpb);
    check("t3_late_count", wq_d.size(), 1);
    check("t3_late_ovf", {31'd0, overflow}, 32'd0);

    // 4: framing error
    flush();
    fe_w = 0;
    send_frame(8'h81, 1'b0, t);
    rx = 1'b1;
    idle(2 * Cpb);
    check("t4_fe", fe_n, 1);
    check("t4_bk", bk_n, 0);
    check("t4_nowrite", wq_d.size(), 0);

    // 5: line break
    flush();
    rx = 1'b0;
    idle(30 * Cpb);
    check("t5_fe", fe_n, 1);
    check("t5_bk", bk_n, 1);
    check("t5_busy_hold", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    idle(Cpb);
    check("t5_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h55, 1'b1, t);
    idle(Cpb);
    check("t5_count", wq_d.size(), 1);
    if (wq_d.size() == 1) check("t5_data", wq_d[0], 32'h55);
    check("t5_fe_after", fe_n, 1);

    // 6: short glitch
    flush();
    rx = 1'b0;
    idle(4);
    check("t6_glitch_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    idle(2 * Cpb);
    check("t6_glitch_idle", {31'd0, busy}, 32'd0);
    check("t6_glitch_none", wq_d.size() + fe_n + bk_n, 0);

    // 6b: reset in the middle of the data bits
    fifo_full = 1'b1;
    send_frame(8'h77, 1'b1, t);
    fifo_full = 1'b0;
    idle(4);
    check("t6_pre_ovf", {31'd0, overflow}, 32'd1);
    flush();
    rx = 1'b0;
    idle(Cpb);
    rx = 1'b1;
    idle(Cpb);
    rx = 1'b0;
    idle(Cpb);
    check("t6_mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_outs",
          {27'd0, write_en, overflow, frame_err, break_det, busy},
          32'd0);
    @(negedge clk);
    rx = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(12 * Cpb);
    check("t6_rst_nowrite", wq_d.size() + fe_n, 0);
    send_frame(8'h12, 1'b1, t);
    idle(Cpb);
    check("t6_after_count", wq_d.size(), 1);
    if (wq_d.size() == 1) check("t6_after_data", wq_d[0], 32'h12);

    // 7: randomized frame mix against the frame model
    flush();
    exp_q.delete();
    fe_exp = 0;
    bk_exp = 0;
    ov_exp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      ff = ($urandom_range(0, 3) == 0);
      if (k == 5) begin
        b = 8'h00;
        st = 1'b0;
      end
      fifo_full = ff;
      send_frame(b, st, t);
      if (!st) begin
        fe_exp++;
        if (b == 8'h00) bk_exp++;
        rx = 1'b1;
        idle(Cpb);
      end else if (ff) begin
        ov_exp = 1'b1;
      end else begin
        exp_q.push_back(int'(b));
      end
    end
    fifo_full = 1'b0;
    idle(2 * Cpb);
    check("t7_count", wq_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wq_d.size()) check("t7_data", wq_d[i], exp_q[i]);
    check("t7_fe", fe_n, fe_exp);
    check("t7_bk", bk_n, bk_exp);
    check("t7_ovf", {31'd0, overflow}, {31'd0, ov_exp});
    check("t7_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
